// File: rtl/del_frame_streamer.sv
// Frame buffer for the EDE delay-smoothing filter: loads one frame from the host,
// then replays it over valid/ready with PAD edge-replicated samples at each end.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_LOAD   | host writes fill the buffer; start accepted once full
// S_STREAM | beats 0..N+2*PAD-1 replayed with first/last sample padding
// S_DONE   | one cycle after the last beat is accepted; frame_done pulse
module del_frame_streamer #(
  parameter int DW  = 10,
  parameter int N   = 2400,
  parameter int PAD = 7,
  parameter int AW  = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          iREADY,
  output logic [DW-1:0] oDEL,
  output logic          oVALID,
  output logic          oSOF,
  output logic          oEOF,
  output logic [AW-1:0] fill,
  output logic          full,
  output logic          busy,
  output logic          frame_done,
  output logic          wr_err
);

  localparam logic [AW-1:0] N_C     = AW'(N);
  localparam logic [AW-1:0] NM1_C   = AW'(N - 1);
  localparam logic [AW-1:0] PAD_C   = AW'(PAD);
  localparam logic [AW-1:0] HI_C    = AW'(N - 1 + PAD);
  localparam logic [AW-1:0] TOTAL_C = AW'(N + 2 * PAD);
  localparam logic [AW-1:0] LAST_C  = AW'(N + 2 * PAD - 1);

  typedef enum logic [1:0] {S_LOAD, S_STREAM, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   fill_q, fill_d;
  logic [AW-1:0]   rd_b_q, rd_b_d;
  logic            wr_err_q, wr_err_d;
  logic            r_vld_q, r_vld_d, r_sof_q, r_sof_d, r_eof_q, r_eof_d;
  logic            o_vld_q, o_vld_d, o_sof_q, o_sof_d, o_eof_q, o_eof_d;
  logic [DW-1:0]   o_del_q, o_del_d;
  logic [DW-1:0]   rd_data_q;
  logic [DW-1:0]   mem [N];
  logic [AW-1:0]   rd_addr;
  logic            full_int, start_ok, mem_we, o_take, r_move, rd_en, last_take;

  assign full_int  = (fill_q == N_C);
  assign start_ok  = (state_q == S_LOAD) && start && full_int;
  assign mem_we    = (state_q == S_LOAD) && wr_en && !full_int;
  assign o_take    = o_vld_q && iREADY;
  // Two-stage pipe (RAM data register + output register) acts as its own skid:
  // a read is only issued when the RAM register will be free next cycle.
  assign r_move    = r_vld_q && (!o_vld_q || iREADY);
  assign rd_en     = (state_q == S_STREAM) && (rd_b_q != TOTAL_C) && (!r_vld_q || r_move);
  assign last_take = o_take && o_eof_q;

  always_comb begin
    rd_addr = rd_b_q - PAD_C;
    if (rd_b_q < PAD_C)       rd_addr = '0;
    else if (rd_b_q >= HI_C)  rd_addr = NM1_C;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[fill_q] <= wr_data;
    if (rd_en)  rd_data_q   <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:   if (start_ok) state_d = S_STREAM;
      S_STREAM: if (last_take) state_d = S_DONE;
      S_DONE:   state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
  end

  always_comb begin
    busy       = (state_q == S_STREAM);
    frame_done = (state_q == S_DONE);
  end

  always_comb begin
    fill_d   = fill_q;
    wr_err_d = wr_err_q;
    rd_b_d   = rd_b_q;
    r_vld_d  = r_vld_q;
    r_sof_d  = r_sof_q;
    r_eof_d  = r_eof_q;
    o_vld_d  = o_vld_q;
    o_sof_d  = o_sof_q;
    o_eof_d  = o_eof_q;
    o_del_d  = o_del_q;
    if (mem_we)                fill_d = fill_q + AW'(1);
    if (last_take)             fill_d = '0;
    if (wr_en && !mem_we)      wr_err_d = 1'b1;
    if (start_ok)              wr_err_d = 1'b0;
    if (start_ok)              rd_b_d = '0;
    else if (rd_en)            rd_b_d = rd_b_q + AW'(1);
    if (rd_en) begin
      r_vld_d = 1'b1;
      r_sof_d = (rd_b_q == '0);
      r_eof_d = (rd_b_q == LAST_C);
    end else if (r_move) begin
      r_vld_d = 1'b0;
    end
    if (r_move) begin
      o_vld_d = 1'b1;
      o_del_d = rd_data_q;
      o_sof_d = r_sof_q;
      o_eof_d = r_eof_q;
    end else if (o_take) begin
      o_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q   <= '0;
      wr_err_q <= 1'b0;
      rd_b_q   <= '0;
      r_vld_q  <= 1'b0;
      r_sof_q  <= 1'b0;
      r_eof_q  <= 1'b0;
      o_vld_q  <= 1'b0;
      o_sof_q  <= 1'b0;
      o_eof_q  <= 1'b0;
      o_del_q  <= '0;
    end else begin
      fill_q   <= fill_d;
      wr_err_q <= wr_err_d;
      rd_b_q   <= rd_b_d;
      r_vld_q  <= r_vld_d;
      r_sof_q  <= r_sof_d;
      r_eof_q  <= r_eof_d;
      o_vld_q  <= o_vld_d;
      o_sof_q  <= o_sof_d;
      o_eof_q  <= o_eof_d;
      o_del_q  <= o_del_d;
    end
  end

  assign oDEL   = o_del_q;
  assign oVALID = o_vld_q;
  assign oSOF   = o_vld_q && o_sof_q;
  assign oEOF   = o_vld_q && o_eof_q;
  assign fill   = fill_q;
  assign full   = full_int;
  assign wr_err = wr_err_q;

endmodule
